// File: rtl/period_meter_if.sv
// period_meter_if: event input, valid/ack readout and status outputs of period_meter.
// master is the meter side, slave is the consumer/stimulus side.
interface period_meter_if;
  logic        event_in;
  logic        period_ack;
  logic [31:0] period;
  logic        period_valid;
  logic        overrun;
  logic        timeout;
  logic [4:0]  edge_count;

  modport master (
    input  event_in,
    input  period_ack,
    output period,
    output period_valid,
    output overrun,
    output timeout,
    output edge_count
  );

  modport slave (
    output event_in,
    output period_ack,
    input  period,
    input  period_valid,
    input  overrun,
    input  timeout,
    input  edge_count
  );
endinterface

// File: rtl/period_meter.sv
// period_meter: counts clock cycles between rising edges of event_in, returns them via valid/ack.
// Define PERIOD_METER_SYNC_EN to add a two-flop input synchronizer (two more cycles of latency).
module period_meter #(
  parameter logic [31:0] TIMEOUT = 32'd1_000_000
) (
  input logic            clock,
  input logic            reset,
  period_meter_if.master bus
);

  typedef enum logic {S_IDLE, S_MEASURE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_ev_s;
  logic        r_ev_d;
  logic        r_armed;
  logic        w_rise;
  logic [31:0] r_cnt;
  logic [31:0] w_cnt_next;
  logic [31:0] r_period;
  logic        w_load;
  logic        w_timeout_next;
  logic        r_valid;
  logic        r_overrun;
  logic        r_timeout;
  logic [4:0]  r_edge_count;

`ifdef PERIOD_METER_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= bus.event_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_ev_s = r_sync2;
`else
  assign w_ev_s = bus.event_in;
`endif

  // r_armed stops a level already high at reset release from counting as a rising edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ev_d  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_ev_d  <= w_ev_s;
      r_armed <= r_armed | ~w_ev_s;
    end
  end

  assign w_rise = w_ev_s & ~r_ev_d & r_armed;

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_load         = 1'b0;
    w_timeout_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_cnt_next   = 32'd1;
          w_state_next = S_MEASURE;
        end else begin
          w_cnt_next = 32'd0;
        end
      end
      S_MEASURE: begin
        if (w_rise) begin
          w_load     = 1'b1;
          w_cnt_next = 32'd1;
        end else if (r_cnt == TIMEOUT) begin
          w_timeout_next = 1'b1;
          w_cnt_next     = 32'd0;
          w_state_next   = S_IDLE;
        end else begin
          w_cnt_next = r_cnt + 32'd1;
        end
      end
      default: begin
        w_cnt_next   = 32'd0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 32'd0;
      r_period     <= 32'd0;
      r_valid      <= 1'b0;
      r_overrun    <= 1'b0;
      r_timeout    <= 1'b0;
      r_edge_count <= 5'd0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_timeout <= w_timeout_next;
      if (w_load) begin
        r_period <= r_cnt;
      end
      if (w_load) begin
        r_valid <= 1'b1;
      end else if (bus.period_ack) begin
        r_valid <= 1'b0;
      end
      // an ack in the same cycle as a new result wins over setting overrun
      if (bus.period_ack) begin
        r_overrun <= 1'b0;
      end else if (w_load && r_valid) begin
        r_overrun <= 1'b1;
      end
      if (w_rise) begin
        r_edge_count <= r_edge_count + 5'd1;
      end
    end
  end

  assign bus.period       = r_period;
  assign bus.period_valid = r_valid;
  assign bus.overrun      = r_overrun;
  assign bus.timeout      = r_timeout;
  assign bus.edge_count   = r_edge_count;

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed stimulus pushes expected results; a negedge monitor pops and compares
// every new measurement the meter presents. Works with and without PERIOD_METER_SYNC_EN.
module tb_period_meter;

  localparam logic [31:0] TMO = 32'd20;
`ifdef PERIOD_METER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    logic [31:0] period;
    logic        ovr;
    logic [4:0]  ecnt;
    int          cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_no   = 0;
  int   n_pulses = 0;
  logic [2:0] ack_pipe = 3'b000;

  period_meter_if bus();

  period_meter #(.TIMEOUT(TMO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc_no);
    end
  endtask

  // ack is delayed like event_in so ack indices line up with the synchronized edge
  task automatic step(input logic ev_v, input logic ack_v);
    @(posedge clock);
    #1;
    cyc_no++;
    bus.event_in = ev_v;
    ack_pipe = {ack_pipe[1:0], ack_v};
    bus.period_ack = ack_pipe[LAT];
  endtask

  task automatic run_gap(input int n, input int ack_i);
    for (int i = 1; i <= n; i++) step(i == n, i == ack_i);
  endtask

  task automatic expect_result(input logic [31:0] p, input logic o, input logic [4:0] e);
    exp_t x;
    x.period = p;
    x.ovr    = o;
    x.ecnt   = e;
    x.cyc    = cyc_no + 1 + LAT;
    exp_q.push_back(x);
    $display("stim: rise at cycle %0d, expect period %0d overrun %0d edge_count %0d", cyc_no, p, o, e);
  endtask

  initial begin : monitor
    exp_t        x;
    logic        pv;
    logic [31:0] pp;
    pv = 1'b0;
    pp = 32'd0;
    forever begin
      @(negedge clock);
      if (bus.period_valid === 1'b1 && (pv !== 1'b1 || bus.period !== pp)) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got period %0d, expected no result", bus.period);
        end else begin
          x = exp_q.pop_front();
          $display("mon: cycle %0d period %0d overrun %0d edge_count %0d", cyc_no, bus.period,
                   bus.overrun, bus.edge_count);
          check("period", 64'(bus.period), 64'(x.period));
          check("overrun_at_result", 64'(bus.overrun), 64'(x.ovr));
          check("edge_count_at_result", 64'(bus.edge_count), 64'(x.ecnt));
          check("result_cycle", 64'(cyc_no), 64'(x.cyc));
        end
      end
      pv = bus.period_valid;
      pp = bus.period;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_period"}, 64'(bus.period), 64'd0);
    check({tag, "_valid"}, 64'(bus.period_valid), 64'd0);
    check({tag, "_overrun"}, 64'(bus.overrun), 64'd0);
    check({tag, "_timeout"}, 64'(bus.timeout), 64'd0);
    check({tag, "_edge_count"}, 64'(bus.edge_count), 64'd0);
  endtask

  initial begin : stimulus
    reset          = 1'b0;
    bus.event_in   = 1'b0;
    bus.period_ack = 1'b0;
    repeat (3) step(1'b0, 1'b0);
    check_all_zero("reset");
    reset = 1'b1;
    repeat (3) step(1'b0, 1'b0);

    // rises every 10 cycles, each result acked
    step(1'b1, 1'b0);
    run_gap(10, 0);  expect_result(32'd10, 1'b0, 5'd2);
    run_gap(10, 1);  expect_result(32'd10, 1'b0, 5'd3);
    run_gap(10, 1);  expect_result(32'd10, 1'b0, 5'd4);
    run_gap(10, 1);  expect_result(32'd10, 1'b0, 5'd5);
    // next result unread when a new one arrives
    run_gap(7, 0);   expect_result(32'd7, 1'b1, 5'd6);
    step(1'b0, 1'b1);
    repeat (LAT + 1) step(1'b0, 1'b0);
    check("ack_clears_valid", 64'(bus.period_valid), 64'd0);
    check("ack_clears_overrun", 64'(bus.overrun), 64'd0);

    // overrun, then an ack in the same cycle as the next rise
    step(1'b1, 1'b0); expect_result(32'(LAT + 3), 1'b0, 5'd7);
    run_gap(5, 0);    expect_result(32'd5, 1'b1, 5'd8);
    run_gap(6, 6);    expect_result(32'd6, 1'b0, 5'd9);

    // no further edges: single timeout pulse, result left untouched
    for (int k = 1; k <= LAT + 25; k++) begin
      step(1'b0, 1'b0);
      if (bus.timeout === 1'b1) n_pulses++;
      if (k == LAT + 2) begin
        check("simul_ack_valid", 64'(bus.period_valid), 64'd1);
        check("simul_ack_overrun", 64'(bus.overrun), 64'd0);
      end
      if (k == LAT + 20) check("timeout_early", 64'(bus.timeout), 64'd0);
      if (k == LAT + 21) begin
        check("timeout_pulse", 64'(bus.timeout), 64'd1);
        check("timeout_valid_kept", 64'(bus.period_valid), 64'd1);
        check("timeout_period_kept", 64'(bus.period), 64'd6);
      end
      if (k == LAT + 22) check("timeout_width", 64'(bus.timeout), 64'd0);
    end
    check("timeout_pulse_count", 64'(n_pulses), 64'd1);
    $display("stim: timeout pulses seen %0d", n_pulses);
    step(1'b0, 1'b1);
    repeat (LAT + 1) step(1'b0, 1'b0);
    check("ack_after_timeout", 64'(bus.period_valid), 64'd0);

    // a lone rise from IDLE yields no period
    step(1'b1, 1'b0);
    repeat (30) step(1'b0, 1'b0);
    check("lone_rise_edge_count", 64'(bus.edge_count), 64'd10);
    check("lone_rise_no_valid", 64'(bus.period_valid), 64'd0);

    // start a measurement, then reset mid-way with event_in held high
    step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    step(1'b1, 1'b0); expect_result(32'd4, 1'b0, 5'd12);
    repeat (LAT + 2) step(1'b1, 1'b0);
    reset = 1'b0;
    #2;
    check_all_zero("async_reset");
    repeat (2) step(1'b1, 1'b0);
    reset = 1'b1;
    repeat (5) step(1'b1, 1'b0);
    check("held_high_no_edge", 64'(bus.edge_count), 64'd0);
    check("held_high_no_valid", 64'(bus.period_valid), 64'd0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("edge_latency_before", 64'(bus.edge_count), 64'd0);
    for (int k = 1; k <= LAT + 1; k++) begin
      step(1'b0, 1'b0);
      check($sformatf("edge_latency_k%0d", k), 64'(bus.edge_count), (k == LAT + 1) ? 64'd1 : 64'd0);
    end

    // minimum-period rises until edge_count wraps through 0 to 1
    step(1'b1, 1'b0); expect_result(32'(LAT + 2), 1'b0, 5'd2);
    for (int k = 3; k <= 33; k++) begin
      run_gap(2, 1);
      expect_result(32'd2, 1'b0, 5'(k % 32));
    end
    repeat (LAT + 3) step(1'b0, 1'b0);
    check("wrap_edge_count", 64'(bus.edge_count), 64'd1);
    check("results_outstanding", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
